// File: rtl/bus_merge_rr.sv
// bus_merge_rr: merges NUM_CH valid/ready channels onto one registered bus by AND-join or round-robin pick
module bus_merge_rr #(
  parameter int WIDTH = 2,
  parameter int NUM_CH = 4,
  parameter int MODE = 0,
  parameter int CNT_W = 16,
  localparam int SRC_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SRC_W-1:0]        out_src,
  output logic [CNT_W-1:0]        beat_cnt
);
  logic ld, fire, found, out_valid_q, out_valid_d;
  logic [SRC_W-1:0] gnt, idx, rr_ptr_q, rr_ptr_d, out_src_q, out_src_d;
  logic [WIDTH-1:0] join_word, arb_word, out_data_q, out_data_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  always_comb begin
    ld = !out_valid_q | out_ready;
    gnt = '0;
    idx = '0;
    found = 1'b0;
    join_word = '1;
    arb_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = SRC_W'((int'(rr_ptr_q) + i) % NUM_CH);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      join_word = join_word & in_data[c*WIDTH +: WIDTH];
      if (SRC_W'(c) == gnt) arb_word = in_data[c*WIDTH +: WIDTH];
    end
    // reset gates fire so nothing is consumed while the block is held in reset
    fire = !reset & ld & ((MODE == 1) ? |in_valid : &in_valid);
    for (int c = 0; c < NUM_CH; c++)
      in_ready[c] = fire & ((MODE == 1) ? (SRC_W'(c) == gnt) : 1'b1);
    out_data_d = fire ? ((MODE == 1) ? arb_word : join_word) : out_data_q;
    out_src_d = fire ? ((MODE == 1) ? gnt : '0) : out_src_q;
    out_valid_d = fire | (out_valid_q & !out_ready);
    rr_ptr_d = (MODE == 1 && fire) ? ((gnt == SRC_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1) : rr_ptr_q;
    beat_cnt_d = beat_cnt_q + CNT_W'(out_valid_q & out_ready);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_src_q <= '0;
      rr_ptr_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_src_q <= out_src_d;
      rr_ptr_q <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src = out_src_q;
  assign beat_cnt = beat_cnt_q;
endmodule

// File: tb/tb_bus_merge_rr.sv
// tb_bus_merge_rr: directed table-driven bench for JOIN, ARB and counter-wrap configurations
module tb_bus_merge_rr;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] j_d = '0, a_d = '0, w_d = '0;
  logic [3:0] j_v = '0, a_v = '0, w_v = '0, j_ir, a_ir, w_ir;
  logic j_r = 1'b0, a_r = 1'b0, w_r = 1'b0, j_ov, a_ov, w_ov;
  logic [1:0] j_od, a_od, w_od, j_src, a_src, w_src;
  logic [15:0] j_cnt, a_cnt;
  logic [3:0] w_cnt;
  int n_vec = 0, n_err = 0;

  bus_merge_rr #(.WIDTH(2), .NUM_CH(4), .MODE(0), .CNT_W(16)) u_join (
    .clk(clk), .reset(reset), .in_data(j_d), .in_valid(j_v), .in_ready(j_ir), .out_data(j_od),
    .out_valid(j_ov), .out_ready(j_r), .out_src(j_src), .beat_cnt(j_cnt));
  bus_merge_rr #(.WIDTH(2), .NUM_CH(4), .MODE(1), .CNT_W(16)) u_arb (
    .clk(clk), .reset(reset), .in_data(a_d), .in_valid(a_v), .in_ready(a_ir), .out_data(a_od),
    .out_valid(a_ov), .out_ready(a_r), .out_src(a_src), .beat_cnt(a_cnt));
  bus_merge_rr #(.WIDTH(2), .NUM_CH(4), .MODE(0), .CNT_W(4)) u_wrap (
    .clk(clk), .reset(reset), .in_data(w_d), .in_valid(w_v), .in_ready(w_ir), .out_data(w_od),
    .out_valid(w_ov), .out_ready(w_r), .out_src(w_src), .beat_cnt(w_cnt));

  typedef struct {
    bit arb;
    logic [7:0] d;
    logic [3:0] v;
    logic rdy;
    logic [3:0] e_ir;
    logic e_ov;
    logic [1:0] e_od;
    logic [1:0] e_src;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int k, input vec_t t);
    if (t.arb) begin a_d = t.d; a_v = t.v; a_r = t.rdy; end
    else begin j_d = t.d; j_v = t.v; j_r = t.rdy; end
    #1;
    chk($sformatf("v%0d in_ready", k), 32'(t.arb ? a_ir : j_ir), 32'(t.e_ir));
    @(negedge clk);
    chk($sformatf("v%0d out_valid", k), 32'(t.arb ? a_ov : j_ov), 32'(t.e_ov));
    chk($sformatf("v%0d out_data", k), 32'(t.arb ? a_od : j_od), 32'(t.e_od));
    chk($sformatf("v%0d out_src", k), 32'(t.arb ? a_src : j_src), 32'(t.e_src));
    chk($sformatf("v%0d beat_cnt", k), 32'(t.arb ? a_cnt : j_cnt), 32'(t.e_cnt));
  endtask

  initial begin
    // JOIN: channel data packed as {ch3,ch2,ch1,ch0}
    tbl.push_back('{1'b0, 8'hDF, 4'hF, 1'b1, 4'hF, 1'b1, 2'd1, 2'd0, 16'd0});
    tbl.push_back('{1'b0, 8'hFF, 4'hF, 1'b1, 4'hF, 1'b1, 2'd3, 2'd0, 16'd1});
    tbl.push_back('{1'b0, 8'hB6, 4'h7, 1'b1, 4'h0, 1'b0, 2'd3, 2'd0, 16'd2});
    tbl.push_back('{1'b0, 8'hB6, 4'hF, 1'b0, 4'hF, 1'b1, 2'd0, 2'd0, 16'd2});
    tbl.push_back('{1'b0, 8'hFF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 2'd0, 16'd2});
    tbl.push_back('{1'b0, 8'hAA, 4'hF, 1'b1, 4'hF, 1'b1, 2'd2, 2'd0, 16'd3});
    tbl.push_back('{1'b0, 8'h55, 4'h0, 1'b1, 4'h0, 1'b0, 2'd2, 2'd0, 16'd4});
    // ARB: channel c carries value c
    tbl.push_back('{1'b1, 8'hE4, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 2'd0, 16'd0});
    tbl.push_back('{1'b1, 8'hE4, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 2'd1, 16'd1});
    tbl.push_back('{1'b1, 8'hE4, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 2'd2, 16'd2});
    tbl.push_back('{1'b1, 8'hE4, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 2'd3, 16'd3});
    tbl.push_back('{1'b1, 8'hE4, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 2'd0, 16'd4});
    tbl.push_back('{1'b1, 8'hE4, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 2'd1, 16'd5});
    tbl.push_back('{1'b1, 8'hE4, 4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 2'd1, 16'd6});
    tbl.push_back('{1'b1, 8'hE4, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0, 2'd0, 16'd6});
    tbl.push_back('{1'b1, 8'hE4, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 2'd0, 16'd6});
    tbl.push_back('{1'b1, 8'hE4, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 2'd0, 16'd6});
    tbl.push_back('{1'b1, 8'hE4, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 2'd0, 16'd6});
    tbl.push_back('{1'b1, 8'hE4, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 2'd1, 16'd7});

    repeat (2) @(negedge clk);
    chk("rst j_ov", 32'(j_ov), 32'd0);
    chk("rst a_ov", 32'(a_ov), 32'd0);
    chk("rst a_cnt", 32'(a_cnt), 32'd0);
    chk("rst a_src", 32'(a_src), 32'd0);
    chk("rst w_cnt", 32'(w_cnt), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 7; k++) run_vec(k, tbl[k]);

    j_r = 1'b1; j_v = 4'h7; j_d = 8'hFF;
    repeat (5) begin
      #1 chk("t2 partial in_ready", 32'(j_ir), 32'd0);
      @(negedge clk);
      chk("t2 partial out_valid", 32'(j_ov), 32'd0);
    end
    j_v = 4'hF;
    #1 chk("t2 fire in_ready", 32'(j_ir), 32'hF);
    @(negedge clk);
    chk("t2 out_valid", 32'(j_ov), 32'd1);
    chk("t2 out_data", 32'(j_od), 32'd3);

    w_r = 1'b1; w_v = 4'hF; w_d = 8'hFF;
    repeat (17) @(negedge clk);
    chk("t6 cnt after 16 beats", 32'(w_cnt), 32'd0);
    w_v = 4'h0;
    @(negedge clk);
    chk("t6 cnt after 17 beats", 32'(w_cnt), 32'd1);
    chk("t6 drained out_valid", 32'(w_ov), 32'd0);

    for (int k = 7; k < tbl.size(); k++) run_vec(k, tbl[k]);

    a_r = 1'b0; a_v = 4'hF;
    #1 chk("t5 stall in_ready", 32'(a_ir), 32'd0);
    @(negedge clk);
    chk("t5 held out_valid", 32'(a_ov), 32'd1);
    chk("t5 held out_src", 32'(a_src), 32'd1);
    reset = 1'b1; a_r = 1'b1;
    #1 chk("t5 in_ready in reset", 32'(a_ir), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("t5 out_valid", 32'(a_ov), 32'd0);
    chk("t5 beat_cnt", 32'(a_cnt), 32'd0);
    chk("t5 out_src", 32'(a_src), 32'd0);
    chk("t5 out_data", 32'(a_od), 32'd0);
    a_v = 4'hA;
    #1 chk("t5 first grant in_ready", 32'(a_ir), 32'h2);
    @(negedge clk);
    chk("t5 first grant out_src", 32'(a_src), 32'd1);
    chk("t5 first grant out_data", 32'(a_od), 32'd1);
    chk("t5 first grant out_valid", 32'(a_ov), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
